// File: rtl/requant_stage.sv
// requant_stage: four-stage int32 -> int8 requantizer (bias, SRDHM, RDBPOT, offset, clamp).
// Ports: clk/reset, cfg_we/cmd/addr/value writes, in_* and out_* valid/ready streams, busy.
// Macro REQUANT_PER_CHANNEL_EN: per-channel bias/mult/shift tables; otherwise scalar registers.
module requant_stage #(
  parameter int INT32_SIZE   = 32,
  parameter int BYTE_SIZE    = 8,
  parameter int MAX_CHANNELS = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_we,
  input  logic [6:0]            cfg_cmd,
  input  logic [6:0]            cfg_addr,
  input  logic [INT32_SIZE-1:0] cfg_value,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INT32_SIZE-1:0] in_acc,
  input  logic [6:0]            in_channel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BYTE_SIZE-1:0]  out_data,
  output logic [6:0]            out_channel,
  output logic                  busy
);
  localparam int W  = INT32_SIZE;
  localparam int PW = 2 * INT32_SIZE;
  localparam int SW = $clog2(INT32_SIZE);

  localparam logic [W-1:0]  MIN_W    = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]  MAX_W    = {1'b0, {(W-1){1'b1}}};
  localparam logic [PW-1:0] NUDGE_P  = PW'(1) << (W - 2);
  localparam logic [PW-1:0] NUDGE_N  = PW'(1) - NUDGE_P;
  localparam logic [W-1:0]  AMIN_RST = W'(-(2 ** (BYTE_SIZE - 1)));
  localparam logic [W-1:0]  AMAX_RST = W'((2 ** (BYTE_SIZE - 1)) - 1);

  logic wr_bias, wr_mult, wr_shift;
  logic wr_off, wr_min, wr_max;

  assign wr_bias  = cfg_we && (cfg_cmd == 7'd1);
  assign wr_mult  = cfg_we && (cfg_cmd == 7'd2);
  assign wr_shift = cfg_we && (cfg_cmd == 7'd3);
  assign wr_off   = cfg_we && (cfg_cmd == 7'd4);
  assign wr_min   = cfg_we && (cfg_cmd == 7'd5);
  assign wr_max   = cfg_we && (cfg_cmd == 7'd6);

  logic [W-1:0] bias_rd;
  logic [W-1:0] mult_rd;
  logic [5:0]   shift_rd;

`ifdef REQUANT_PER_CHANNEL_EN
  logic [W-1:0] bias_mem  [MAX_CHANNELS];
  logic [W-1:0] mult_mem  [MAX_CHANNELS];
  logic [5:0]   shift_mem [MAX_CHANNELS];

  // Tables survive reset. The read below is combinational, so an item
  // accepted on the same edge as a write still sees the old entry.
  always_ff @(posedge clk) begin
    if (wr_bias)  bias_mem[cfg_addr]  <= cfg_value;
    if (wr_mult)  mult_mem[cfg_addr]  <= cfg_value;
    if (wr_shift) shift_mem[cfg_addr] <= cfg_value[5:0];
  end

  assign bias_rd  = bias_mem[in_channel];
  assign mult_rd  = mult_mem[in_channel];
  assign shift_rd = shift_mem[in_channel];
`else
  logic [W-1:0] bias_q, bias_d;
  logic [W-1:0] mult_q, mult_d;
  logic [5:0]   shift_q, shift_d;
  logic         unused_addr;

  assign unused_addr = ^cfg_addr;

  always_comb begin
    bias_d  = wr_bias  ? cfg_value      : bias_q;
    mult_d  = wr_mult  ? cfg_value      : mult_q;
    shift_d = wr_shift ? cfg_value[5:0] : shift_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bias_q  <= '0;
      mult_q  <= '0;
      shift_q <= '0;
    end else begin
      bias_q  <= bias_d;
      mult_q  <= mult_d;
      shift_q <= shift_d;
    end
  end

  assign bias_rd  = bias_q;
  assign mult_rd  = mult_q;
  assign shift_rd = shift_q;
`endif

  // Split the signed 6-bit shift into left / right amounts.
  // A code of -32 saturates to the widest right shift.
  logic signed [5:0] sh_s;
  logic [5:0]        sh_neg;
  logic [SW-1:0]     lsh_rd;
  logic [SW-1:0]     rsh_rd;

  always_comb begin
    sh_s   = $signed(shift_rd);
    sh_neg = 6'(-sh_s);
    lsh_rd = '0;
    rsh_rd = '0;
    if (!sh_s[5]) begin
      lsh_rd = SW'(sh_s);
    end else begin
      rsh_rd = sh_neg[5] ? SW'(W - 1) : SW'(sh_neg);
    end
  end

  logic [W-1:0]  offset_q, offset_d;
  logic [W-1:0]  act_min_q, act_min_d;
  logic [W-1:0]  act_max_q, act_max_d;

  logic          v1_q, v1_d;
  logic [6:0]    ch1_q, ch1_d;
  logic [W-1:0]  sum1_q, sum1_d;
  logic [W-1:0]  mult1_q, mult1_d;
  logic [SW-1:0] lsh1_q, lsh1_d;
  logic [SW-1:0] rsh1_q, rsh1_d;

  logic          v2_q, v2_d;
  logic [6:0]    ch2_q, ch2_d;
  logic [PW-1:0] prod2_q, prod2_d;
  logic          sat2_q, sat2_d;
  logic [SW-1:0] rsh2_q, rsh2_d;

  logic          v3_q, v3_d;
  logic [6:0]    ch3_q, ch3_d;
  logic [W-1:0]  hi3_q, hi3_d;
  logic [SW-1:0] rsh3_q, rsh3_d;

  logic                 out_valid_q, out_valid_d;
  logic [6:0]           out_channel_q, out_channel_d;
  logic [BYTE_SIZE-1:0] out_data_q, out_data_d;

  logic en;

  assign en = !out_valid_q || out_ready;

  logic [W-1:0]         a2;
  logic signed [PW-1:0] p2;
  logic [PW-1:0]        t3;
  logic signed [PW-1:0] q3;
  logic [W-1:0]         x4, mask4, rem4, thr4;
  logic signed [W-1:0]  sr4, r4, v4;

  always_comb begin
    // S2: left shift then full-width signed product
    a2 = sum1_q << lsh1_q;
    p2 = $signed({{W{a2[W-1]}}, a2}) *
         $signed({{W{mult1_q[W-1]}}, mult1_q});

    // S3: nudge, then divide by 2^(W-1) rounding toward zero
    t3 = prod2_q + (prod2_q[PW-1] ? NUDGE_N : NUDGE_P);
    q3 = $signed(t3) >>> (W - 1);
    if (t3[PW-1] && (t3[W-2:0] != '0)) begin
      q3 = q3 + PW'(1);
    end

    // S4: rounding right shift, offset, clamp (max then min)
    x4    = hi3_q;
    mask4 = (W'(1) << rsh3_q) - W'(1);
    rem4  = x4 & mask4;
    thr4  = (mask4 >> 1) + W'(x4[W-1]);
    sr4   = $signed(x4) >>> rsh3_q;
    r4    = sr4 + W'(rem4 > thr4);
    v4    = r4 + $signed(offset_q);
    if (v4 < $signed(act_min_q)) v4 = $signed(act_min_q);
    if (v4 > $signed(act_max_q)) v4 = $signed(act_max_q);
  end

  logic unused_bits;

  assign unused_bits = ^{q3[PW-1:W], v4[W-1:BYTE_SIZE]};

  always_comb begin
    offset_d  = wr_off ? cfg_value : offset_q;
    act_min_d = wr_min ? cfg_value : act_min_q;
    act_max_d = wr_max ? cfg_value : act_max_q;

    v1_d          = v1_q;
    ch1_d         = ch1_q;
    sum1_d        = sum1_q;
    mult1_d       = mult1_q;
    lsh1_d        = lsh1_q;
    rsh1_d        = rsh1_q;
    v2_d          = v2_q;
    ch2_d         = ch2_q;
    prod2_d       = prod2_q;
    sat2_d        = sat2_q;
    rsh2_d        = rsh2_q;
    v3_d          = v3_q;
    ch3_d         = ch3_q;
    hi3_d         = hi3_q;
    rsh3_d        = rsh3_q;
    out_valid_d   = out_valid_q;
    out_channel_d = out_channel_q;
    out_data_d    = out_data_q;

    if (en) begin
      v1_d    = in_valid;
      ch1_d   = in_channel;
      sum1_d  = in_acc + bias_rd;
      mult1_d = mult_rd;
      lsh1_d  = lsh_rd;
      rsh1_d  = rsh_rd;

      v2_d    = v1_q;
      ch2_d   = ch1_q;
      prod2_d = p2;
      sat2_d  = (a2 == MIN_W) && (mult1_q == MIN_W);
      rsh2_d  = rsh1_q;

      v3_d    = v2_q;
      ch3_d   = ch2_q;
      hi3_d   = sat2_q ? MAX_W : q3[W-1:0];
      rsh3_d  = rsh2_q;

      out_valid_d   = v3_q;
      out_channel_d = ch3_q;
      out_data_d    = v4[BYTE_SIZE-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      offset_q      <= '0;
      act_min_q     <= AMIN_RST;
      act_max_q     <= AMAX_RST;
      v1_q          <= 1'b0;
      ch1_q         <= '0;
      sum1_q        <= '0;
      mult1_q       <= '0;
      lsh1_q        <= '0;
      rsh1_q        <= '0;
      v2_q          <= 1'b0;
      ch2_q         <= '0;
      prod2_q       <= '0;
      sat2_q        <= 1'b0;
      rsh2_q        <= '0;
      v3_q          <= 1'b0;
      ch3_q         <= '0;
      hi3_q         <= '0;
      rsh3_q        <= '0;
      out_valid_q   <= 1'b0;
      out_channel_q <= '0;
      out_data_q    <= '0;
    end else begin
      offset_q      <= offset_d;
      act_min_q     <= act_min_d;
      act_max_q     <= act_max_d;
      v1_q          <= v1_d;
      ch1_q         <= ch1_d;
      sum1_q        <= sum1_d;
      mult1_q       <= mult1_d;
      lsh1_q        <= lsh1_d;
      rsh1_q        <= rsh1_d;
      v2_q          <= v2_d;
      ch2_q         <= ch2_d;
      prod2_q       <= prod2_d;
      sat2_q        <= sat2_d;
      rsh2_q        <= rsh2_d;
      v3_q          <= v3_d;
      ch3_q         <= ch3_d;
      hi3_q         <= hi3_d;
      rsh3_q        <= rsh3_d;
      out_valid_q   <= out_valid_d;
      out_channel_q <= out_channel_d;
      out_data_q    <= out_data_d;
    end
  end

  assign in_ready    = en;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_channel = out_channel_q;
  assign busy        = v1_q || v2_q || v3_q || out_valid_q;

endmodule

// File: tb/tb_requant_stage.sv
// tb_requant_stage: random + directed stimulus against an arithmetic reference model.
// Checks results, order, latency, stall stability, reset behaviour and busy.
module tb_requant_stage;

  logic        clk;
  logic        reset;
  logic        cfg_we;
  logic [6:0]  cfg_cmd;
  logic [6:0]  cfg_addr;
  logic [31:0] cfg_value;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_acc;
  logic [6:0]  in_channel;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [6:0]  out_channel;
  logic        busy;

  requant_stage dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_we      (cfg_we),
    .cfg_cmd     (cfg_cmd),
    .cfg_addr    (cfg_addr),
    .cfg_value   (cfg_value),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_acc      (in_acc),
    .in_channel  (in_channel),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_channel (out_channel),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int n_rx   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_bias [128];
  int m_mult [128];
  int m_shift[128];
  int m_off, m_lo, m_hi;

  function automatic int idx(input logic [6:0] ch);
`ifdef REQUANT_PER_CHANNEL_EN
    return int'(ch);
`else
    return 0;
`endif
  endfunction

  function automatic int srdhm(input int a, input int b);
    longint p, n;
    if (a == 32'sh80000000 && b == 32'sh80000000) return 32'sh7fffffff;
    p = longint'(a) * longint'(b);
    n = (p >= 0) ? (longint'(1) << 30) : (longint'(1) - (longint'(1) << 30));
    return int'((p + n) / 64'sd2147483648);
  endfunction

  function automatic int rdbpot(input int x, input int e);
    int mask, rem, thr;
    mask = int'((longint'(1) << e) - 1);
    rem  = x & mask;
    thr  = (mask >>> 1) + ((x < 0) ? 1 : 0);
    return (x >>> e) + ((rem > thr) ? 1 : 0);
  endfunction

  function automatic logic [7:0] ref_out(input int acc, input int b,
                                         input int m, input int sh);
    int a, x, v;
    logic [31:0] vb;
    a = acc + b;
    if (sh > 0) a = a << sh;
    x = srdhm(a, m);
    x = rdbpot(x, (sh < 0) ? -sh : 0);
    v = x + m_off;
    if (v < m_lo) v = m_lo;
    if (v > m_hi) v = m_hi;
    vb = v;
    return vb[7:0];
  endfunction

  typedef struct {
    logic [7:0] d;
    logic [6:0] c;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  logic held;
  logic [7:0] held_d;
  logic [6:0] held_c;

  initial held = 1'b0;

  // Monitor on the falling edge: everything seen here is what the
  // next rising edge will act on.
  always @(negedge clk) begin
    if (reset) begin
      expq.delete();
      held  = 1'b0;
      m_off = 0;
      m_lo  = -128;
      m_hi  = 127;
`ifndef REQUANT_PER_CHANNEL_EN
      m_bias[0]  = 0;
      m_mult[0]  = 0;
      m_shift[0] = 0;
`endif
    end else begin
      check_eq("busy", busy, expq.size() != 0);
      check_eq("in_ready", in_ready, !out_valid || out_ready);
      if (held) begin
        check_eq("hold_valid", out_valid, 1);
        check_eq("hold_data", out_data, held_d);
        check_eq("hold_ch", out_channel, held_c);
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          check_eq("spurious_out", out_valid, 0);
        end else begin
          mon_e = expq.pop_front();
          check_eq("out_data", out_data, mon_e.d);
          check_eq("out_ch", out_channel, mon_e.c);
          n_rx++;
        end
      end
      held   = out_valid && !out_ready;
      held_d = out_data;
      held_c = out_channel;
      if (in_valid && in_ready) begin
        mon_e.d = ref_out(int'(in_acc), m_bias[idx(in_channel)],
                          m_mult[idx(in_channel)], m_shift[idx(in_channel)]);
        mon_e.c = in_channel;
        expq.push_back(mon_e);
      end
      if (cfg_we) begin
        case (cfg_cmd)
          7'd1: m_bias[idx(cfg_addr)]  = int'(cfg_value);
          7'd2: m_mult[idx(cfg_addr)]  = int'(cfg_value);
          7'd3: m_shift[idx(cfg_addr)] = int'($signed(cfg_value[5:0]));
          7'd4: m_off = int'(cfg_value);
          7'd5: m_lo  = int'(cfg_value);
          7'd6: m_hi  = int'(cfg_value);
          default: ;
        endcase
      end
    end
  end

  // ---------------- driver tasks (start/end at posedge + 1) ----------------
  task automatic cfg(input logic [6:0] cmd, input logic [6:0] addr,
                     input logic [31:0] val);
    cfg_we    = 1'b1;
    cfg_cmd   = cmd;
    cfg_addr  = addr;
    cfg_value = val;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid  = 1'b0;
    cfg_we    = 1'b0;
    out_ready = 1'b1;
    while (busy && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("drain", busy, 0);
  endtask

  task automatic lat_test(input string tag, input logic [31:0] acc,
                          input logic [7:0] exp_d);
    int n;
    n = 0;
    in_valid   = 1'b1;
    in_acc     = acc;
    in_channel = 7'd3;
    do begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n++;
    end while (!out_valid && n < 10);
    check_eq({tag, "_lat"}, n, 4);
    check_eq({tag, "_data"}, out_data, exp_d);
    check_eq({tag, "_ch"}, out_channel, 3);
    @(posedge clk);
    #1;
  endtask

  int sent;
  int rx0;

  initial begin
    reset     = 1'b1;
    cfg_we    = 1'b0;
    cfg_cmd   = '0;
    cfg_addr  = '0;
    cfg_value = '0;
    in_valid  = 1'b0;
    in_acc    = '0;
    in_channel = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_ch", out_channel, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_in_ready", in_ready, 1);

    // basic scaling, latency 4
    cfg(1, 3, 24);
    cfg(2, 3, 32'h40000000);
    cfg(3, 3, 32'(-3));
    cfg(4, 0, 0);
    lat_test("basic", 1000, 8'd64);

    // negative rounding through both SRDHM and RDBPOT
    cfg(1, 3, 0);
    cfg(3, 3, 32'(-1));
    cfg(4, 0, 3);
    lat_test("negrnd", 32'(-5), 8'd2);

    // clamp to both rails
    cfg(2, 3, 32'h7fffffff);
    cfg(3, 3, 0);
    cfg(4, 0, 32'(-128));
    lat_test("clamp_hi", 1000000, 8'd127);
    lat_test("clamp_lo", 32'(-1000000), 8'h80);

    // SRDHM saturation
    cfg(2, 3, 32'h80000000);
    cfg(4, 0, 0);
    lat_test("sat", 32'h80000000, 8'd127);

    // act_min above act_max yields act_max
    cfg(5, 0, 10);
    cfg(6, 0, 32'(-20));
    lat_test("inv_clamp", 0, 8'hEC);
    cfg(5, 0, 32'(-128));
    cfg(6, 0, 127);

    // same-cycle table write uses old value; next item sees new one
    cfg(2, 3, 32'h40000000);
    cfg(1, 3, 0);
    cfg_we     = 1'b1;
    cfg_cmd    = 7'd1;
    cfg_addr   = 7'd3;
    cfg_value  = 100;
    in_valid   = 1'b1;
    in_acc     = 100;
    in_channel = 7'd3;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();

    // back-to-back items with a 4-cycle output stall
    rx0  = n_rx;
    sent = 0;
    for (int c = 0; c < 40 && (sent < 6 || busy); c++) begin
      out_ready  = !(c >= 5 && c <= 8);
      in_valid   = (sent < 6);
      in_acc     = 32'(int'($urandom_range(400)) - 200);
      in_channel = 7'd3;
      @(negedge clk);
      if (c >= 5 && c <= 8 && out_valid) check_eq("stall_in_ready", in_ready, 0);
      if (in_valid && in_ready) sent++;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
    check_eq("b2b_sent", sent, 6);
    check_eq("b2b_rx", n_rx - rx0, 6);

    // reset with three items in flight
    in_channel = 7'd3;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_acc   = 32'(k * 10);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check_eq("inflight_busy", busy, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("mid_rst_valid", out_valid, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_in_ready", in_ready, 1);
    check_eq("mid_rst_data", out_data, 0);
    repeat (10) @(posedge clk);
    #1;
    check_eq("post_rst_quiet", out_valid, 0);

    // randomized traffic
    for (int ch = 0; ch < 8; ch++) begin
      cfg(1, 7'(ch), 32'(int'($urandom_range(20000)) - 10000));
      cfg(2, 7'(ch), 32'h40000000 + $urandom_range(32'h0fffffff));
      cfg(3, 7'(ch), 32'(int'($urandom_range(40)) - 31));
    end
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 149) begin
        drain();
        cfg(4, 0, 32'(int'($urandom_range(60)) - 30));
        cfg(5, 0, 32'(-128 + int'($urandom_range(60))));
        cfg(6, 0, 32'(127 - int'($urandom_range(60))));
      end
      in_valid   = ($urandom_range(99) < 70);
      in_acc     = ($urandom_range(3) == 0) ? $urandom :
                   32'(int'($urandom_range(2097152)) - 1048576);
      in_channel = 7'($urandom_range(7));
      out_ready  = ($urandom_range(99) < 65);
      cfg_we     = ($urandom_range(9) == 0);
      cfg_addr   = 7'($urandom_range(7));
      case ($urandom_range(4))
        0: begin
          cfg_cmd   = 7'd1;
          cfg_value = 32'(int'($urandom_range(20000)) - 10000);
        end
        1: begin
          cfg_cmd   = 7'd2;
          cfg_value = ($urandom_range(1) == 0) ? $urandom :
                      32'h40000000 + $urandom_range(32'h0fffffff);
        end
        2: begin
          cfg_cmd   = 7'd3;
          cfg_value = 32'(int'($urandom_range(62)) - 31);
        end
        3: begin
          cfg_cmd   = 7'd0;
          cfg_value = $urandom;
        end
        default: begin
          cfg_cmd   = 7'd7;
          cfg_value = $urandom;
        end
      endcase
      @(posedge clk);
      #1;
    end
    cfg_we = 1'b0;
    drain();
    check_eq("queue_empty", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/requant_stage.md
REQUANT_STAGE -- requirements
Module: requant_stage

Interface
REQ-001 Parameter INT32_SIZE, default 32: accumulator, bias and multiplier width.
REQ-002 Parameter BYTE_SIZE, default 8: output element width.
REQ-003 Parameter MAX_CHANNELS, default 128: per-channel table depth.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 cfg_we  input  1  config write strobe, one write per cycle.
REQ-007 cfg_cmd  input  7  config target: 1 bias[addr], 2 multiplier[addr], 3 shift[addr], 4 output_offset, 5 act_min, 6 act_max; other codes ignored.
REQ-008 cfg_addr  input  7  channel index for codes 1-3.
REQ-009 cfg_value  input  32  write data; shift uses bits [5:0] as signed, range -31..+31.
REQ-010 in_valid / in_ready  input / output  1 / 1  accumulator handshake; transfer when both high.
REQ-011 in_acc  input  32  signed conv accumulator from the upstream conv1d engine.
REQ-012 in_channel  input  7  output channel of in_acc.
REQ-013 out_valid / out_ready  output / input  1 / 1  result handshake.
REQ-014 out_data  output  8  signed requantized result.
REQ-015 out_channel  output  7  in_channel carried alongside the result.
REQ-016 busy  output  1  high while any pipeline stage holds a valid item.

Function
REQ-017 The result SHALL be clamp(RDBPOT(SRDHM((in_acc+bias[ch]) << max(shift,0), mult[ch]), max(-shift,0)) + output_offset, act_min, act_max); all intermediate int32 math wraps.
REQ-018 SRDHM(a,b) SHALL return INT32_MAX when a==b==INT32_MIN; otherwise 64-bit p=a*b, nudge = p>=0 ? 2^30 : 1-2^30, result = (p+nudge)/2^31 truncated toward zero.
REQ-019 RDBPOT(x,e) SHALL compute mask=2^e-1, rem=x&mask, thr=(mask>>1)+(x<0), result=(x>>>e)+(rem>thr).
REQ-020 The pipeline SHALL have four stages: S1 table read + bias add; S2 left shift + 64-bit multiply; S3 nudge + high word; S4 right shift, offset, clamp.
REQ-021 Latency SHALL be 4 cycles from accepted input to out_valid when out_ready is held high; throughput one item per cycle.
REQ-022 Global advance enable SHALL be (!out_valid || out_ready); in_ready SHALL equal that enable.
REQ-023 When out_valid && !out_ready, all stages SHALL freeze and out_data/out_channel SHALL hold stable.
REQ-024 Items SHALL exit in acceptance order; none dropped or duplicated under any backpressure pattern.
REQ-025 A table write and an input accept for the same channel in the same cycle SHALL use the old table value; items accepted later SHALL use the new one.
REQ-026 Writes to output_offset, act_min, act_max SHALL apply to items in S4 on the following cycle.
REQ-027 act_min > act_max SHALL yield act_max (max applied first, then min).

Reset
REQ-028 On reset: all stage valids 0, out_valid 0, out_data 0, out_channel 0, busy 0, output_offset 0, act_min -128, act_max 127.
REQ-029 Reset mid-operation SHALL discard all in-flight items; in_ready is 1 in the first cycle after reset deasserts.
REQ-030 Bias, multiplier and shift tables SHALL NOT be cleared by reset.

Configuration
REQ-031 Macro REQUANT_PER_CHANNEL_EN defined: bias/multiplier/shift are MAX_CHANNELS-deep tables indexed by cfg_addr and in_channel.
REQ-032 Macro absent: single scalar bias/multiplier/shift registers; cfg_addr and in_channel ignored for lookup (out_channel still carried); scalars reset to 0.

Verification
REQ-033 ch 3: bias 24, mult 0x40000000, shift -3, offset 0; in_acc 1000 -> out_data 64, out_channel 3, exactly 4 cycles later.
REQ-034 bias 0, mult 0x40000000, shift -1, offset 3; in_acc -5 -> out_data 2 (SRDHM -2, RDBPOT -1).
REQ-035 mult 0x7FFFFFFF, shift 0, offset -128; in_acc 1000000 -> out_data 127; in_acc -1000000 -> -128.
REQ-036 mult 0x80000000, bias 0, shift 0; in_acc 0x80000000 -> SRDHM saturates, out_data 127.
REQ-037 6 back-to-back items, out_ready low cycles 5-8 -> in_ready low while stalled, all 6 delivered in order, out_data stable while held.
REQ-038 reset asserted with 3 items in flight -> out_valid 0 next cycle, no stale result ever emitted, busy 0.
